// File: rtl/otp_stream_ctrl.sv
// OTP key-stream controller: seeds the key shifter, arbitrates two requesters and returns data ^ key.
// Optional build macro OTP_CTRL_ROUND_ROBIN_EN selects round-robin arbitration (default: fixed priority).
`ifndef MSG_SIZE
`define MSG_SIZE 32
`endif

module otp_stream_ctrl #(
  parameter int REKEY_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 seed_valid,
  input  logic [7:0]           seed,
  output logic                 seed_ready,
  input  logic                 req0_valid,
  input  logic [`MSG_SIZE-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [`MSG_SIZE-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 out_valid,
  output logic [`MSG_SIZE-1:0] out_data,
  output logic                 out_id,
  input  logic                 out_ready,
  output logic                 key_load,
  output logic [7:0]           key_seed,
  output logic                 key_shift,
  input  logic [`MSG_SIZE-1:0] key_in,
  output logic                 rekey_needed,
  output logic                 busy
);

  localparam int CW = $clog2(REKEY_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, READY, OUT, SHIFT, EXHAUSTED
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             key_seed_q, key_seed_d;
  logic [`MSG_SIZE-1:0]   out_data_q, out_data_d;
  logic                   out_id_q, out_id_d;
  logic [CW-1:0]          msg_count_q, msg_count_d;
  logic                   seed_hs, req_hs, grant0, grant1, tie_to_1;

`ifdef OTP_CTRL_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // Resets to 1 so requester 0 wins the very first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (req_hs) last_grant_d = req1_ready;
  end

  assign tie_to_1 = ~last_grant_q;
`else
  assign tie_to_1 = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      key_seed_q  <= '0;
      out_data_q  <= '0;
      out_id_q    <= 1'b0;
      msg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      key_seed_q  <= key_seed_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      msg_count_q <= msg_count_d;
    end
  end

  // A pending seed in READY suppresses all grants so the reload wins cleanly.
  always_comb begin
    seed_ready = (state_q == IDLE) || (state_q == READY) || (state_q == EXHAUSTED);
    seed_hs    = seed_ready && seed_valid;
    grant1     = req1_valid && (!req0_valid || tie_to_1);
    grant0     = req0_valid && !grant1;
    req0_ready = (state_q == READY) && !seed_valid && grant0;
    req1_ready = (state_q == READY) && !seed_valid && grant1;
    req_hs     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  end

  always_comb begin
    state_d     = state_q;
    key_seed_d  = key_seed_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    msg_count_d = msg_count_q;
    unique case (state_q)
      IDLE, EXHAUSTED: if (seed_hs) state_d = LOAD;
      LOAD:            state_d = SETTLE;
      SETTLE:          state_d = READY;
      READY: begin
        if (seed_hs) begin
          state_d = LOAD;
        end else if (req_hs) begin
          state_d    = OUT;
          out_data_d = req1_ready ? (req1_data ^ key_in) : (req0_data ^ key_in);
          out_id_d   = req1_ready;
        end
      end
      OUT:             if (out_ready) state_d = SHIFT;
      SHIFT: begin
        msg_count_d = msg_count_q + CW'(1);
        state_d     = (msg_count_d == CW'(REKEY_LIMIT)) ? EXHAUSTED : READY;
      end
      default:         state_d = IDLE;
    endcase
    if (seed_hs) begin
      key_seed_d  = seed;
      msg_count_d = '0;
    end
  end

  assign out_valid    = (state_q == OUT);
  assign out_data     = out_data_q;
  assign out_id       = out_id_q;
  assign key_load     = (state_q == LOAD);
  assign key_shift    = (state_q == SHIFT);
  assign key_seed     = key_seed_q;
  assign rekey_needed = (state_q == EXHAUSTED);
  assign busy         = (state_q == LOAD) || (state_q == SETTLE) ||
                        (state_q == OUT)  || (state_q == SHIFT);

endmodule

// File: tb/tb_otp_stream_ctrl.sv
// Self-checking bench for otp_stream_ctrl (REKEY_LIMIT=2): vector table plus
// hand-written back-pressure, reset-in-OUT and contention/rekey sequences.
`ifndef MSG_SIZE
`define MSG_SIZE 32
`endif

module tb_otp_stream_ctrl;

  localparam logic [31:0] K  = 32'hA5A5A5A5;
  localparam logic [31:0] D0 = 32'h0F0F0F0F;
  localparam logic [31:0] R  = 32'hAAAAAAAA;
  localparam logic [31:0] B  = 32'hB791F3DD;
  localparam logic [31:0] Z  = 32'h00000000;
  localparam logic [31:0] F  = 32'h00FFFF00;

  logic        clk, reset;
  logic        seed_valid, seed_ready;
  logic [7:0]  seed, key_seed;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_data, req1_data, out_data, key_in;
  logic        out_valid, out_id, out_ready;
  logic        key_load, key_shift, rekey_needed, busy;

  int checks = 0;
  int failures = 0;

  otp_stream_ctrl #(.REKEY_LIMIT(2)) dut (
    .clk(clk), .reset(reset),
    .seed_valid(seed_valid), .seed(seed), .seed_ready(seed_ready),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
    .key_load(key_load), .key_seed(key_seed), .key_shift(key_shift), .key_in(key_in),
    .rekey_needed(rekey_needed), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic sv; logic [7:0] sd; logic r0v; logic [31:0] r0d; logic r1v; logic [31:0] r1d;
    logic ordy; logic [31:0] key;
    logic eSR; logic eR0; logic eR1; logic eOV; logic [31:0] eOD; logic eID;
    logic eLd; logic eSh; logic [7:0] eKS; logic eBusy; logic eRk;
  } vec_t;

  vec_t vecs[22];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    seed_valid = v.sv;  seed = v.sd;
    req0_valid = v.r0v; req0_data = v.r0d;
    req1_valid = v.r1v; req1_data = v.r1d;
    out_ready  = v.ordy; key_in = v.key;
  endtask

  task automatic waitOut(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    if (!out_valid) checkOutput("out_valid wait timeout", 32'(out_valid), 32'(1'b1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    logic expIds[4];
    logic [31:0] expData;
`ifdef OTP_CTRL_ROUND_ROBIN_EN
    expIds = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    expIds = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    //            sv    sd     r0v   r0d          r1v   r1d           ordy  key            eSR   eR0   eR1   eOV   eOD  eID   eLd   eSh   eKS    eBusy eRk
    vecs[0]  = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b0, K,             1'b1, 1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, Z,           1'b0, Z,            1'b0, K,             1'b1, 1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, D0,          1'b0, Z,            1'b0, K,             1'b0, 1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, D0,          1'b0, Z,            1'b0, K,             1'b0, 1'b0, 1'b0, 1'b0, Z,   1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, D0,          1'b0, Z,            1'b0, K,             1'b1, 1'b1, 1'b0, 1'b0, Z,   1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b0, K,             1'b0, 1'b0, 1'b0, 1'b1, R,   1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b1, K,             1'b0, 1'b0, 1'b0, 1'b1, R,   1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b1, K,             1'b0, 1'b0, 1'b0, 1'b0, R,   1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, Z,           1'b1, 32'h12345678, 1'b0, K,             1'b1, 1'b0, 1'b1, 1'b0, R,   1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b1, K,             1'b0, 1'b0, 1'b0, 1'b1, B,   1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b0, K,             1'b0, 1'b0, 1'b0, 1'b0, B,   1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, D0,          1'b0, Z,            1'b0, K,             1'b1, 1'b0, 1'b0, 1'b0, B,   1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 8'h3C, 1'b1, D0,          1'b0, Z,            1'b0, K,             1'b1, 1'b0, 1'b0, 1'b0, B,   1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b0, K,             1'b0, 1'b0, 1'b0, 1'b0, B,   1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b0, K,             1'b0, 1'b0, 1'b0, 1'b0, B,   1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 8'hC3, 1'b1, D0,          1'b1, D0,           1'b0, K,             1'b1, 1'b0, 1'b0, 1'b0, B,   1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b0, K,             1'b0, 1'b0, 1'b0, 1'b0, B,   1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b0, K,             1'b0, 1'b0, 1'b0, 1'b0, B,   1'b1, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 32'h00FF00FF, 1'b0, Z,           1'b0, 32'h0000FFFF,  1'b1, 1'b1, 1'b0, 1'b0, B,   1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b1, K,             1'b0, 1'b0, 1'b0, 1'b1, F,   1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b0, K,             1'b0, 1'b0, 1'b0, 1'b0, F,   1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 1'b0, Z,           1'b0, Z,            1'b0, K,             1'b1, 1'b0, 1'b0, 1'b0, F,   1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0};

    // Reset values while reset is held low.
    reset = 1'b0;
    applyStimulus(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset seed_ready", 32'(seed_ready), 32'(1'b1));
    checkOutput("reset out_valid", 32'(out_valid), 32'(1'b0));
    checkOutput("reset out_data", out_data, Z);
    checkOutput("reset out_id", 32'(out_id), 32'(1'b0));
    checkOutput("reset key_load", 32'(key_load), 32'(1'b0));
    checkOutput("reset key_shift", 32'(key_shift), 32'(1'b0));
    checkOutput("reset key_seed", 32'(key_seed), 32'(8'h00));
    checkOutput("reset busy", 32'(busy), 32'(1'b0));
    checkOutput("reset rekey_needed", 32'(rekey_needed), 32'(1'b0));
    reset = 1'b1;

    // Table: load, single message, second requester, exhaustion, seed priority.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d seed_ready", i), 32'(seed_ready), 32'(vecs[i].eSR));
      checkOutput($sformatf("vec%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].eR0));
      checkOutput($sformatf("vec%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].eR1));
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].eOV));
      checkOutput($sformatf("vec%0d out_data", i), out_data, vecs[i].eOD);
      checkOutput($sformatf("vec%0d out_id", i), 32'(out_id), 32'(vecs[i].eID));
      checkOutput($sformatf("vec%0d key_load", i), 32'(key_load), 32'(vecs[i].eLd));
      checkOutput($sformatf("vec%0d key_shift", i), 32'(key_shift), 32'(vecs[i].eSh));
      checkOutput($sformatf("vec%0d key_seed", i), 32'(key_seed), 32'(vecs[i].eKS));
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].eBusy));
      checkOutput($sformatf("vec%0d rekey_needed", i), 32'(rekey_needed), 32'(vecs[i].eRk));
      tick();
    end

    // Back-pressure: READY with count 1, hold OUT for 10 cycles.
    applyStimulus(vecs[21]);
    req0_valid = 1'b1; req0_data = D0; key_in = K;
    tick();
    req1_valid = 1'b1; req1_data = D0;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'(1'b1));
      checkOutput($sformatf("bp%0d out_data", i), out_data, R);
      checkOutput($sformatf("bp%0d key_shift", i), 32'(key_shift), 32'(1'b0));
      checkOutput($sformatf("bp%0d req0_ready", i), 32'(req0_ready), 32'(1'b0));
      checkOutput($sformatf("bp%0d req1_ready", i), 32'(req1_ready), 32'(1'b0));
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    tick();
    checkOutput("bp release key_shift", 32'(key_shift), 32'(1'b1));
    tick();
    checkOutput("bp exhausted rekey_needed", 32'(rekey_needed), 32'(1'b1));
    checkOutput("bp exhausted key_shift", 32'(key_shift), 32'(1'b0));

    // Reset asserted while a result is pending in OUT.
    out_ready = 1'b0; seed_valid = 1'b1; seed = 8'h5A;
    tick();
    seed_valid = 1'b0;
    tick();
    tick();
    req0_valid = 1'b1; req0_data = D0;
    tick();
    req0_valid = 1'b0;
    checkOutput("rst pre out_valid", 32'(out_valid), 32'(1'b1));
    #2 reset = 1'b0;
    #1;
    checkOutput("rst async out_valid", 32'(out_valid), 32'(1'b0));
    checkOutput("rst async out_data", out_data, Z);
    checkOutput("rst async key_load", 32'(key_load), 32'(1'b0));
    checkOutput("rst async key_shift", 32'(key_shift), 32'(1'b0));
    checkOutput("rst async key_seed", 32'(key_seed), 32'(8'h00));
    #2 reset = 1'b1;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rst idle%0d seed_ready", i), 32'(seed_ready), 32'(1'b1));
      checkOutput($sformatf("rst idle%0d req0_ready", i), 32'(req0_ready), 32'(1'b0));
      checkOutput($sformatf("rst idle%0d out_valid", i), 32'(out_valid), 32'(1'b0));
      checkOutput($sformatf("rst idle%0d busy", i), 32'(busy), 32'(1'b0));
    end

    // Contention with a rekey after two messages.
    req0_valid = 1'b0;
    seed_valid = 1'b1; seed = 8'h66;
    tick();
    seed_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h01010101;
    req1_valid = 1'b1; req1_data = 32'h02020202;
    out_ready = 1'b1; key_in = K;
    for (int m = 0; m < 4; m++) begin
      waitOut(n);
      checkOutput($sformatf("cont%0d wait cycles", m), 32'(n), (m == 0 || m == 2) ? 32'd3 : 32'd1);
      checkOutput($sformatf("cont%0d out_id", m), 32'(out_id), 32'(expIds[m]));
      expData = expIds[m] ? 32'hA7A7A7A7 : 32'hA4A4A4A4;
      checkOutput($sformatf("cont%0d out_data", m), out_data, expData);
      tick();
      checkOutput($sformatf("cont%0d key_shift", m), 32'(key_shift), 32'(1'b1));
      tick();
      if (m == 1) begin
        for (int s = 0; s < 3; s++) begin
          checkOutput($sformatf("stall%0d rekey_needed", s), 32'(rekey_needed), 32'(1'b1));
          checkOutput($sformatf("stall%0d req0_ready", s), 32'(req0_ready), 32'(1'b0));
          checkOutput($sformatf("stall%0d req1_ready", s), 32'(req1_ready), 32'(1'b0));
          checkOutput($sformatf("stall%0d out_valid", s), 32'(out_valid), 32'(1'b0));
          tick();
        end
        seed_valid = 1'b1; seed = 8'h99;
        #1;
        checkOutput("reseed seed_ready", 32'(seed_ready), 32'(1'b1));
        tick();
        seed_valid = 1'b0;
        checkOutput("reseed rekey cleared", 32'(rekey_needed), 32'(1'b0));
        checkOutput("reseed key_load", 32'(key_load), 32'(1'b1));
        checkOutput("reseed key_seed", 32'(key_seed), 32'(8'h99));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
